// File: rtl/dtw_accel_pkg.sv
// rtl/dtw_accel_pkg.sv - shared DTW packet constants: tags, FSM encodings, trailer layout
package dtw_accel_pkg;

   localparam logic [15:0] DTW_MAGIC     = 16'hDA7A;
   localparam logic [31:0] PAD_WORD      = 32'hFFFF_FFFF;
   localparam int          PKT_WORDS     = 8;
   localparam int          SLOTS_PER_PKT = 3;
   localparam logic [1:0]  LAST_SLOT     = 2'(SLOTS_PER_PKT - 1);

   localparam logic [2:0] ST_IDLE     = 3'd0;
   localparam logic [2:0] ST_HDR      = 3'd1;
   localparam logic [2:0] ST_POS      = 3'd2;
   localparam logic [2:0] ST_SCO      = 3'd3;
   localparam logic [2:0] ST_WAIT_RES = 3'd4;
   localparam logic [2:0] ST_PAD_P    = 3'd5;
   localparam logic [2:0] ST_PAD_S    = 3'd6;
   localparam logic [2:0] ST_TRL      = 3'd7;

   // Trailer bit offsets; the host driver decodes packets with these.
   localparam int TRL_CSUM_LSB   = 16;
   localparam int TRL_SEQ_LSB    = 8;
   localparam int TRL_NVALID_LSB = 0;

   function automatic logic [31:0] header_word(input logic [15:0] magic, input logic [7:0] seq);
      return {magic, seq, 8'h00};
   endfunction

   function automatic logic [31:0] trailer_word(input logic [15:0] csum, input logic [7:0] seq,
                                                input logic [2:0] nvalid);
      return {csum, seq, 5'b0, nvalid};
   endfunction

endpackage

// File: rtl/dtw_result_packer.sv
// rtl/dtw_result_packer.sv - frames DTW results into 8-word packets for the output-stream FIFO
// Optional trailer checksum enabled by defining DTW_PKT_CSUM_EN.
module dtw_result_packer
   import dtw_accel_pkg::*;
#(
   parameter int          C_M_AXIS_TDATA_WIDTH = 32,
   parameter int          POS_W                = 32,
   parameter int          SCORE_W              = 32,
   parameter logic [15:0] MAGIC                = DTW_MAGIC
) (
   input  logic                            M_AXIS_ACLK,
   input  logic                            M_AXIS_ARESETN,
   input  logic                            res_valid,
   output logic                            res_ready,
   input  logic [POS_W-1:0]                res_pos,
   input  logic [SCORE_W-1:0]              res_score,
   input  logic                            res_last,
   output logic                            dtw_fifo_wren,
   output logic [C_M_AXIS_TDATA_WIDTH-1:0] dtw_fifo_din,
   input  logic                            dtw_fifo_full,
   output logic                            pkt_busy
);

   logic [2:0]         state_q, state_d;
   logic [7:0]         seq_q, seq_d;
   logic [1:0]         slot_q, slot_d;
   logic [2:0]         nvalid_q, nvalid_d;
   logic               last_seen_q, last_seen_d;
   logic [POS_W-1:0]   pos_q, pos_d;
   logic [SCORE_W-1:0] score_q, score_d;
   logic [31:0]        word;
   logic [15:0]        csum16;
   logic               emit;
   logic               res_xfer;

   assign emit = (state_q != ST_IDLE) && (state_q != ST_WAIT_RES);
   assign dtw_fifo_wren = emit && !dtw_fifo_full;
   assign dtw_fifo_din  = word;
   assign res_ready     = !emit;
   assign pkt_busy      = (state_q != ST_IDLE);
   assign res_xfer      = res_valid && res_ready;

   always_comb begin
      state_d     = state_q;
      seq_d       = seq_q;
      slot_d      = slot_q;
      nvalid_d    = nvalid_q;
      last_seen_d = last_seen_q;
      pos_d       = pos_q;
      score_d     = score_q;
      word        = '0;
      case (state_q)
         ST_IDLE, ST_WAIT_RES: begin
            if (res_xfer) begin
               pos_d       = res_pos;
               score_d     = res_score;
               last_seen_d = res_last;
               nvalid_d    = (state_q == ST_IDLE) ? 3'd1 : nvalid_q + 3'd1;
               state_d     = (state_q == ST_IDLE) ? ST_HDR : ST_POS;
            end
         end
         ST_HDR: begin
            word = header_word(MAGIC, seq_q);
            if (dtw_fifo_wren) state_d = ST_POS;
         end
         ST_POS: begin
            word = 32'(pos_q);
            if (dtw_fifo_wren) state_d = ST_SCO;
         end
         ST_SCO: begin
            word = 32'(score_q);
            if (dtw_fifo_wren) begin
               slot_d = slot_q + 2'd1;
               if (slot_q == LAST_SLOT)  state_d = ST_TRL;
               else if (last_seen_q)     state_d = ST_PAD_P;
               else                      state_d = ST_WAIT_RES;
            end
         end
         ST_PAD_P: begin
            word = PAD_WORD;
            if (dtw_fifo_wren) state_d = ST_PAD_S;
         end
         ST_PAD_S: begin
            word = PAD_WORD;
            if (dtw_fifo_wren) begin
               slot_d  = slot_q + 2'd1;
               state_d = (slot_q == LAST_SLOT) ? ST_TRL : ST_PAD_P;
            end
         end
         default: begin
            word = trailer_word(csum16, seq_q, nvalid_q);
            if (dtw_fifo_wren) begin
               seq_d       = seq_q + 8'd1;
               slot_d      = 2'd0;
               nvalid_d    = 3'd0;
               last_seen_d = 1'b0;
               state_d     = ST_IDLE;
            end
         end
      endcase
   end

`ifdef DTW_PKT_CSUM_EN
   logic [15:0] csum_q, csum_d;

   // Trailer write clears the sum so the next packet starts fresh.
   always_comb begin
      csum_d = csum_q;
      if (dtw_fifo_wren)
         csum_d = (state_q == ST_TRL) ? 16'h0000 : (csum_q ^ word[31:16] ^ word[15:0]);
   end

   always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
      if (!M_AXIS_ARESETN) csum_q <= 16'h0000;
      else                 csum_q <= csum_d;
   end

   assign csum16 = csum_q;
`else
   assign csum16 = 16'h0000;
`endif

   always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
      if (!M_AXIS_ARESETN) begin
         state_q     <= ST_IDLE;
         seq_q       <= 8'd0;
         slot_q      <= 2'd0;
         nvalid_q    <= 3'd0;
         last_seen_q <= 1'b0;
         pos_q       <= '0;
         score_q     <= '0;
      end else begin
         state_q     <= state_d;
         seq_q       <= seq_d;
         slot_q      <= slot_d;
         nvalid_q    <= nvalid_d;
         last_seen_q <= last_seen_d;
         pos_q       <= pos_d;
         score_q     <= score_d;
      end
   end

endmodule

// File: tb/tb_dtw_result_packer.sv
// tb/tb_dtw_result_packer.sv - scoreboard bench for dtw_result_packer
module tb_dtw_result_packer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        res_valid = 1'b0;
   logic        res_ready;
   logic [31:0] res_pos = '0;
   logic [31:0] res_score = '0;
   logic        res_last = 1'b0;
   logic        dtw_fifo_wren;
   logic [31:0] dtw_fifo_din;
   logic        dtw_fifo_full;
   logic        pkt_busy;

   logic        full_force = 1'b0;
   logic        full_rand = 1'b0;
   logic        rand_en = 1'b0;

   int          checks = 0;
   int          failures = 0;
   int          wcount = 0;
   logic [31:0] exp_q[$];
   logic [7:0]  mseq = 8'd0;
   logic [31:0] rp[3];
   logic [31:0] rs[3];

   assign dtw_fifo_full = full_force | (rand_en & full_rand);

   dtw_result_packer dut (
      .M_AXIS_ACLK    (clk),
      .M_AXIS_ARESETN (rst_n),
      .res_valid      (res_valid),
      .res_ready      (res_ready),
      .res_pos        (res_pos),
      .res_score      (res_score),
      .res_last       (res_last),
      .dtw_fifo_wren  (dtw_fifo_wren),
      .dtw_fifo_din   (dtw_fifo_din),
      .dtw_fifo_full  (dtw_fifo_full),
      .pkt_busy       (pkt_busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      #1;
      full_rand = ($urandom_range(0, 3) == 0);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Scoreboard: every written word must be the next expected one.
   always @(negedge clk) begin
      if (dtw_fifo_full) check("wren_on_full", {31'b0, dtw_fifo_wren}, 32'd0);
      if (dtw_fifo_wren) begin
         wcount++;
         check("ready_in_emit", {31'b0, res_ready}, 32'd0);
         check("word_expected", {31'b0, exp_q.size() != 0}, 32'd1);
         if (exp_q.size() != 0) check("word", dtw_fifo_din, exp_q.pop_front());
      end
   end

   task automatic push_packet(input int n);
      logic [31:0] w[8];
      logic [15:0] cs;
      w[0] = {16'hDA7A, mseq, 8'h00};
      for (int i = 0; i < 3; i++) begin
         w[1+2*i] = (i < n) ? rp[i] : 32'hFFFF_FFFF;
         w[2+2*i] = (i < n) ? rs[i] : 32'hFFFF_FFFF;
      end
      cs = 16'h0000;
`ifdef DTW_PKT_CSUM_EN
      for (int i = 0; i < 7; i++) cs = cs ^ w[i][31:16] ^ w[i][15:0];
`endif
      w[7] = {cs, mseq, 5'b0, 3'(n)};
      for (int i = 0; i < 8; i++) exp_q.push_back(w[i]);
      mseq = mseq + 8'd1;
   endtask

   task automatic send_result(input logic [31:0] p, input logic [31:0] s, input logic l);
      int t;
      bit done;
      t = 0;
      done = 0;
      res_pos = p;
      res_score = s;
      res_last = l;
      res_valid = 1'b1;
      while (!done) begin
         @(negedge clk);
         if (res_ready) done = 1;
         else begin
            t++;
            if (t > 200) begin
               check("ready_timeout", 32'd0, 32'd1);
               done = 1;
            end
         end
      end
      @(posedge clk);
      #1;
      res_valid = 1'b0;
   endtask

   task automatic send_packet(input int n);
      push_packet(n);
      for (int i = 0; i < n; i++) send_result(rp[i], rs[i], i == n - 1);
   endtask

   task automatic drain();
      int t;
      t = 0;
      while ((exp_q.size() != 0 || pkt_busy) && t < 500) begin
         @(posedge clk);
         t++;
      end
      #1;
      check("drain_done", {31'b0, exp_q.size() == 0 && !pkt_busy}, 32'd1);
   endtask

   initial begin
      int w0;
      int t;
      repeat (3) @(posedge clk);
      #1;
      check("rst_wren", {31'b0, dtw_fifo_wren}, 32'd0);
      check("rst_busy", {31'b0, pkt_busy}, 32'd0);
      rst_n = 1'b1;
      #1;
      check("rst_ready", {31'b0, res_ready}, 32'd1);

      // Single result with last: padded packet, header one cycle after transfer.
      rp[0] = 32'h10; rs[0] = 32'h55;
      push_packet(1);
      send_result(rp[0], rs[0], 1'b1);
      @(negedge clk);
      check("lat_hdr_wren", {31'b0, dtw_fifo_wren}, 32'd1);
      check("lat_hdr_din", dtw_fifo_din, 32'hDA7A_0000);
      drain();

      // Three results fill the packet without padding.
      rp = '{32'd1, 32'd2, 32'd3}; rs = '{32'd7, 32'd8, 32'd9};
      w0 = wcount;
      send_packet(3);
      drain();
      check("three_res_writes", 32'(wcount - w0), 32'd8);

      // Backpressure while slot 1 position word is pending.
      rp = '{32'hA0, 32'hA1, 32'hA2}; rs = '{32'hB0, 32'hB1, 32'hB2};
      push_packet(3);
      send_result(rp[0], rs[0], 1'b0);
      send_result(rp[1], rs[1], 1'b0);
      full_force = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp_wren", {31'b0, dtw_fifo_wren}, 32'd0);
         check("bp_din", dtw_fifo_din, rp[1]);
      end
      @(posedge clk);
      #1;
      full_force = 1'b0;
      send_result(rp[2], rs[2], 1'b1);
      drain();

      // Sequence number wrap over many single-result packets.
      for (int k = 0; k < 257; k++) begin
         rp[0] = $urandom; rs[0] = $urandom;
         send_packet(1);
         drain();
      end

      // Random sizes under random backpressure.
      rand_en = 1'b1;
      for (int k = 0; k < 12; k++) begin
         for (int i = 0; i < 3; i++) begin
            rp[i] = $urandom; rs[i] = $urandom;
         end
         send_packet($urandom_range(1, 3));
         drain();
      end
      rand_en = 1'b0;

      // Async reset while the slot 0 score word is current.
      exp_q.push_back({16'hDA7A, mseq, 8'h00});
      exp_q.push_back(32'h0000_0BAD);
      send_result(32'h0000_0BAD, 32'h0000_0C0D, 1'b1);
      t = 0;
      while (exp_q.size() != 0 && t < 50) begin
         @(posedge clk);
         #1;
         t++;
      end
      check("pre_rst_popped", 32'(exp_q.size()), 32'd0);
      rst_n = 1'b0;
      #1;
      check("arst_wren", {31'b0, dtw_fifo_wren}, 32'd0);
      check("arst_busy", {31'b0, pkt_busy}, 32'd0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      exp_q.delete();
      mseq = 8'd0;

      // Post-reset packet also exercises the checksum halves.
      rp[0] = 32'h0001_0002; rs[0] = 32'h0;
      push_packet(1);
      send_result(rp[0], rs[0], 1'b1);
      @(negedge clk);
      check("post_rst_hdr", dtw_fifo_din, 32'hDA7A_0000);
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout observed=%0d expected=0", 1);
      $fatal(1);
   end

endmodule
